// File: rtl/mwadd_pkg.sv
// Shared definitions for the limb-serial multiword adder.
// Provides the FSM state encoding and the limb-counter width helper.
// No logic; imported by multiword_adder_seq.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limb counter width; a single-limb build still needs a 1-bit counter.
  function automatic int cnt_width(input int limbs);
    return (limbs <= 1) ? 1 : $clog2(limbs);
  endfunction

endpackage

// File: rtl/rca.sv
// Purpose: N-bit combinational ripple-carry adder used for one limb per cycle.
// Ports: x, y (N-bit operands), C_in (carry in) -> sum (N-bit), C_out (carry out),
//        overflow (two's-complement overflow: carry into MSB XOR carry out of MSB).
module rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         C_in,
  output logic [N-1:0] sum,
  output logic         C_out,
  output logic         overflow
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = C_in;
    for (int i = 0; i < N; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign C_out    = c[N];
  assign overflow = c[N] ^ c[N-1];

endmodule

// File: rtl/multiword_adder_seq.sv
// Purpose: limb-serial wide adder/subtractor; one N-bit limb per cycle (LSB first) through
//          a single rca instance, carry chained through a register, wide result plus flags.
// Ports: clk, rst (async, active-high); start_valid/start_ready + a, b (+ sub) request side;
//        res_valid/res_ready + result, carry_out, overflow, zero response side.
// Optional: define MWADD_SUB_EN to add the sub port (a - b as a + ~b + 1); otherwise add only.
module multiword_adder_seq
  import mwadd_pkg::*;
#(
  parameter int N     = 8,
  parameter int LIMBS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
`ifdef MWADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [N*LIMBS-1:0] a,
  input  logic [N*LIMBS-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N*LIMBS-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int W  = N * LIMBS;
  localparam int CW = cnt_width(LIMBS);
  localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

  logic sub_s;
`ifdef MWADD_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          carry_q, carry_d;
  logic          carry_out_q, carry_out_d;
  logic          overflow_q, overflow_d;
  logic          zero_q, zero_d;
  logic          start_ready_q, start_ready_d;
  logic          res_valid_q, res_valid_d;

  logic [N-1:0]  limb_x, limb_y, limb_sum;
  logic          limb_cout, limb_ovf;

  assign limb_x = a_q[cnt_q*N +: N];
  assign limb_y = b_q[cnt_q*N +: N];

  rca #(.N(N)) u_rca (
    .x        (limb_x),
    .y        (limb_y),
    .C_in     (carry_q),
    .sum      (limb_sum),
    .C_out    (limb_cout),
    .overflow (limb_ovf)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    carry_d       = carry_q;
    carry_out_d   = carry_out_q;
    overflow_d    = overflow_q;
    zero_d        = zero_q;
    start_ready_d = start_ready_q;
    res_valid_d   = res_valid_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d           = a;
          // Subtraction is a + ~b + 1: invert b here, the +1 enters as the first carry.
          b_d           = sub_s ? ~b : b;
          carry_d       = sub_s;
          cnt_d         = '0;
          start_ready_d = 1'b0;
          state_d       = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*N +: N] = limb_sum;
        carry_d                = limb_cout;
        cnt_d                  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Lower limbs were all written earlier in this operation, so result_d is complete.
          carry_out_d = limb_cout;
          overflow_d  = limb_ovf;
          zero_d      = (result_d == '0);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d   = 1'b0;
          start_ready_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      carry_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      result_q      <= result_d;
      carry_q       <= carry_d;
      carry_out_q   <= carry_out_d;
      overflow_q    <= overflow_d;
      zero_q        <= zero_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;

endmodule
